regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//   Shares the register file's single write port (we3/wa3/wd3, written on negedge clk) between
//   the pipeline writeback stage and a multi-cycle unit (divider/load) that returns results late.
//   Keeps a 32-entry pending scoreboard of registers awaiting a multi-cycle result and raises a
//   stall request when the multi-cycle result is starved. Sits between WB, the MC unit and regfile.
// PARAMETERS
//   MAX_OUT      4   max outstanding multi-cycle ops (1..31)
//   STARVE_LIM   3   cycles mc_valid may wait un-granted before a forced slot is requested (>=1)
// PORTS
//   clk          in   1   clock, rising edge for all state
//   rst_n        in   1   asynchronous active-low reset
//   wb_we        in   1   writeback write request (never back-pressured)
//   wb_wa        in   5   writeback destination register
//   wb_wd        in   32  writeback data
//   mc_valid     in   1   multi-cycle result valid
//   mc_wa        in   5   multi-cycle destination register
//   mc_wd        in   32  multi-cycle data
//   mc_ready     out  1   multi-cycle result accepted this cycle (valid&ready = transfer)
//   iss_en       in   1   multi-cycle op issued this cycle
//   iss_wa       in   5   destination of issued op
//   iss_ready    out  1   outstanding count < MAX_OUT
//   ra1, ra2     in   5   source registers being decoded
//   busy1, busy2 out  1   source register has a pending multi-cycle write
//   stall_req    out  1   asks pipeline to hold WB bubble (wb_we=0) next cycle
//   we3          out  1   regfile write enable
//   wa3          out  5   regfile write address
//   wd3          out  32  regfile write data
// BEHAVIOUR
//   Reset (async, rst_n=0): pending=0, out_cnt=0, wait_cnt=0, state=IDLE; stall_req=0,
//     iss_ready=1, busy1/2=0; write port outputs follow comb rules (mc_ready=0 unless wb idle).
//   Write mux (combinational, 0 latency): wb_we=1 -> we3=1, wa3=wb_wa, wd3=wb_wd, mc_ready=0.
//     wb_we=0 & mc_valid=1 -> we3=1, wa3=mc_wa, wd3=mc_wd, mc_ready=1. Neither -> we3=0,wa3=0,wd3=0.
//     Any selected wa3==0 -> we3 forced 0 (mc_ready still 1: $0 result is consumed and dropped).
//   FSM (rising edge): IDLE: mc_valid&~mc_ready -> WAIT, wait_cnt=1.
//     WAIT: mc_ready -> IDLE; else wait_cnt++; wait_cnt==STARVE_LIM -> FORCE.
//     FORCE: stall_req=1 (registered, asserted while in FORCE); mc_ready -> IDLE, wait_cnt=0.
//     mc_valid dropping while in WAIT/FORCE is illegal (MC must hold until accepted).
//   Scoreboard: iss_en&iss_ready&iss_wa!=0 sets pending[iss_wa]; mc transfer clears pending[mc_wa].
//     Same cycle set and clear of same register: set wins (newer op outstanding).
//     iss_en with iss_ready=0 ignored (no state change). iss_wa==0: counted but no pending bit.
//   out_cnt: +1 on accepted issue, -1 on mc transfer, both -> unchanged; saturates 0..MAX_OUT.
//     iss_ready = (out_cnt < MAX_OUT), registered-state derived.
//   busy1 = pending[ra1], busy2 = pending[ra2] (registered vector, comb read; ra==0 -> 0).
//     No bypass: result written this cycle still shows busy until next edge.
//   wb_we and mc transfer to same reg same cycle: impossible by mux (wb wins, mc waits).
//   Reset mid-operation: pending and counters cleared; MC unit is reset in the same domain.
// TESTING
//   T1 reset: rst_n=0 with mc_valid=1,wb_we=1 -> stall_req=0,busy=0,iss_ready=1; we3=1,wa3=wb_wa.
//   T2 priority: wb_we=1 wa=5 wd=0x11, mc_valid=1 wa=7 wd=0x22 -> wa3=5,mc_ready=0; next cycle
//      wb_we=0 -> wa3=7,wd3=0x22,mc_ready=1.
//   T3 starvation: STARVE_LIM=3, wb_we=1 continuously, mc_valid=1 -> stall_req=1 from 4th cycle;
//      drop wb_we -> mc transfer, stall_req=0 next cycle.
//   T4 scoreboard: issue wa=9, ra1=9 -> busy1=1 next cycle; mc transfer wa=9 -> busy1=0 after edge;
//      same-cycle issue wa=9 and transfer wa=9 -> busy1 stays 1, out_cnt unchanged.
//   T5 full: 4 issues without completion -> iss_ready=0; 5th iss_en ignored; one transfer ->
//      iss_ready=1.
//   T6 $0: wb_we=1 wb_wa=0 -> we3=0; mc result wa=0 -> mc_ready=1, we3=0, out_cnt decrements.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the regfile write port between WB and a multi-cycle unit, tracks pending regs
module regfile_wr_arbiter #(
  parameter int MAX_OUT    = 4,
  parameter int STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wb_we,
  input  logic [4:0]  i_wb_wa,
  input  logic [31:0] i_wb_wd,
  input  logic        i_mc_valid,
  input  logic [4:0]  i_mc_wa,
  input  logic [31:0] i_mc_wd,
  output logic        o_mc_ready,
  input  logic        i_iss_en,
  input  logic [4:0]  i_iss_wa,
  output logic        o_iss_ready,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic        o_busy1,
  output logic        o_busy2,
  output logic        o_stall_req,
  output logic        o_we3,
  output logic [4:0]  o_wa3,
  output logic [31:0] o_wd3
);
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int WW = $clog2(STARVE_LIM + 2);
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
  state_t         r_state, w_state_nxt;
  logic [WW-1:0]  r_wait_cnt, w_wait_nxt;
  logic [31:0]    r_pending, w_pending_nxt;
  logic [CW-1:0]  r_out_cnt, w_out_nxt;
  logic           w_iss, w_xfer;
  // Writeback always wins the port; a $0 destination is consumed but never written
  always_comb begin
    o_mc_ready = i_mc_valid & ~i_wb_we;
    o_wa3      = i_wb_we ? i_wb_wa : (i_mc_valid ? i_mc_wa : 5'd0);
    o_wd3      = i_wb_we ? i_wb_wd : (i_mc_valid ? i_mc_wd : 32'd0);
    o_we3      = (i_wb_we | i_mc_valid) & (o_wa3 != 5'd0);
  end
  // Starvation FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end
  // Count un-granted cycles of a valid MC result and escalate to a forced slot at the limit
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    case (r_state)
      IDLE: if (i_mc_valid & ~o_mc_ready) begin
        w_wait_nxt  = WW'(1);
        w_state_nxt = (STARVE_LIM <= 1) ? FORCE : WAIT;
      end
      WAIT: if (o_mc_ready) begin
        w_state_nxt = IDLE;
        w_wait_nxt  = '0;
      end else begin
        w_wait_nxt  = r_wait_cnt + 1'b1;
        w_state_nxt = (w_wait_nxt >= WW'(STARVE_LIM)) ? FORCE : WAIT;
      end
      FORCE: if (o_mc_ready) begin
        w_state_nxt = IDLE;
        w_wait_nxt  = '0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_wait_nxt  = '0;
      end
    endcase
  end
  // Stall request is a pure decode of the registered state
  always_comb o_stall_req = (r_state == FORCE);
  assign w_iss  = i_iss_en & o_iss_ready;
  assign w_xfer = i_mc_valid & o_mc_ready;
  // Clear the completing register first so a same-cycle issue to it stays pending
  always_comb begin
    w_pending_nxt = (r_pending & ~(32'(w_xfer) << i_mc_wa)) | (32'(w_iss & (i_iss_wa != 5'd0)) << i_iss_wa);
    w_out_nxt     = (w_iss & ~w_xfer & (r_out_cnt < CW'(MAX_OUT))) ? r_out_cnt + 1'b1 :
                    (w_xfer & ~w_iss & (r_out_cnt != '0)) ? r_out_cnt - 1'b1 : r_out_cnt;
  end
  // Scoreboard and outstanding-op counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_out_cnt <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_out_cnt <= w_out_nxt;
    end
  end
  // Source busy lookup reads only registered state, so no same-cycle bypass
  always_comb begin
    o_iss_ready = r_out_cnt < CW'(MAX_OUT);
    o_busy1     = (i_ra1 != 5'd0) & r_pending[i_ra1];
    o_busy2     = (i_ra2 != 5'd0) & r_pending[i_ra2];
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed and randomized checks against a behavioural model
module tb_regfile_wr_arbiter;
  localparam int MAX = 4;
  localparam int LIM = 3;
  logic clk = 0, rst_n = 0;
  logic wb_we = 0, mc_valid = 0, iss_en = 0;
  logic [4:0] wb_wa = 0, mc_wa = 0, iss_wa = 0, ra1 = 0, ra2 = 0;
  logic [31:0] wb_wd = 0, mc_wd = 0;
  logic mc_ready, iss_ready, busy1, busy2, stall_req, we3;
  logic [4:0] wa3;
  logic [31:0] wd3;
  int n_chk = 0, n_pass = 0;
  bit m_pend[32];
  int m_cnt = 0, m_wait = 0;
  bit last_acc = 0, last_xf = 0;
  logic [4:0] q[$];

  regfile_wr_arbiter #(.MAX_OUT(MAX), .STARVE_LIM(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_we(wb_we), .i_wb_wa(wb_wa), .i_wb_wd(wb_wd),
    .i_mc_valid(mc_valid), .i_mc_wa(mc_wa), .i_mc_wd(mc_wd), .o_mc_ready(mc_ready),
    .i_iss_en(iss_en), .i_iss_wa(iss_wa), .o_iss_ready(iss_ready),
    .i_ra1(ra1), .i_ra2(ra2), .o_busy1(busy1), .o_busy2(busy2), .o_stall_req(stall_req),
    .o_we3(we3), .o_wa3(wa3), .o_wd3(wd3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    logic [4:0] e_wa;
    logic [31:0] e_wd;
    bit e_mcr, e_we, acc;
    #2;
    if (!rst_n) begin
      foreach (m_pend[k]) m_pend[k] = 0;
      m_cnt = 0;
      m_wait = 0;
    end
    e_mcr = mc_valid && !wb_we;
    e_wa  = wb_we ? wb_wa : (mc_valid ? mc_wa : 5'd0);
    e_wd  = wb_we ? wb_wd : (mc_valid ? mc_wd : 32'd0);
    e_we  = (wb_we || mc_valid) && e_wa != 0;
    chk("mc_ready", mc_ready, e_mcr);
    chk("we3", we3, e_we);
    chk("wa3", wa3, e_wa);
    chk("wd3", wd3, e_wd);
    chk("busy1", busy1, ra1 != 0 && m_pend[ra1]);
    chk("busy2", busy2, ra2 != 0 && m_pend[ra2]);
    chk("iss_ready", iss_ready, m_cnt < MAX);
    chk("stall_req", stall_req, m_wait >= LIM);
    last_acc = 0;
    last_xf  = 0;
    if (rst_n) begin
      acc = iss_en && m_cnt < MAX;
      if (e_mcr) m_pend[mc_wa] = 0;
      if (acc && iss_wa != 0) m_pend[iss_wa] = 1;
      if (acc && !e_mcr) m_cnt++;
      else if (e_mcr && !acc && m_cnt > 0) m_cnt--;
      m_wait   = (mc_valid && !e_mcr) ? m_wait + 1 : 0;
      last_acc = acc;
      last_xf  = e_mcr;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wb_we = 0; mc_valid = 0; iss_en = 0;
    wb_wa = 0; mc_wa = 0; iss_wa = 0; wb_wd = 0; mc_wd = 0;
  endtask

  initial begin
    @(negedge clk);
    // T1 reset with both requesters active
    wb_we = 1; wb_wa = 3; wb_wd = 32'hAB; mc_valid = 1; mc_wa = 4; mc_wd = 32'hCD;
    #1 chk("t1_we3", we3, 1);
    chk("t1_wa3", wa3, 3);
    chk("t1_stall", stall_req, 0);
    chk("t1_iss_ready", iss_ready, 1);
    cyc();
    rst_n = 1; idle(); cyc();
    // T2 priority
    wb_we = 1; wb_wa = 5; wb_wd = 32'h11; mc_valid = 1; mc_wa = 7; mc_wd = 32'h22;
    #1 chk("t2_wa3_wb", wa3, 5);
    chk("t2_mcr0", mc_ready, 0);
    cyc();
    wb_we = 0;
    #1 chk("t2_wa3_mc", wa3, 7);
    chk("t2_wd3_mc", wd3, 32'h22);
    chk("t2_mcr1", mc_ready, 1);
    cyc();
    idle(); cyc();
    // T3 starvation
    wb_we = 1; wb_wa = 1; wb_wd = 32'h5; mc_valid = 1; mc_wa = 8; mc_wd = 32'h88;
    cyc(); cyc();
    chk("t3_stall_c3", stall_req, 0);
    cyc();
    chk("t3_stall_c4", stall_req, 1);
    cyc();
    wb_we = 0; cyc();
    chk("t3_stall_clr", stall_req, 0);
    idle(); cyc();
    // T4 scoreboard
    iss_en = 1; iss_wa = 9; ra1 = 9; cyc();
    iss_en = 0;
    chk("t4_busy_set", busy1, 1);
    mc_valid = 1; mc_wa = 9; mc_wd = 32'h99;
    #1 chk("t4_no_bypass", busy1, 1);
    cyc();
    chk("t4_busy_clr", busy1, 0);
    mc_valid = 0; iss_en = 1; cyc();
    mc_valid = 1; cyc();
    chk("t4_set_wins", busy1, 1);
    iss_en = 0; cyc();
    chk("t4_cleared", busy1, 0);
    mc_valid = 0;
    // T5 full
    for (int i = 0; i < 4; i++) begin
      iss_en = 1; iss_wa = 5'(10 + i); cyc();
    end
    chk("t5_full", iss_ready, 0);
    iss_wa = 14; ra1 = 14; cyc();
    chk("t5_ignored", busy1, 0);
    iss_en = 0; mc_valid = 1; mc_wa = 10; cyc();
    chk("t5_ready_again", iss_ready, 1);
    idle();
    // T6 register $0
    wb_we = 1; wb_wa = 0; wb_wd = 32'h77;
    #1 chk("t6_wb_zero", we3, 0);
    cyc();
    wb_we = 0; mc_valid = 1; mc_wa = 0; mc_wd = 32'h66;
    #1 chk("t6_mcr", mc_ready, 1);
    chk("t6_we3", we3, 0);
    cyc();
    idle(); iss_en = 1; iss_wa = 15; cyc();
    chk("t6_cnt_dec", iss_ready, 1);
    iss_wa = 16; cyc();
    chk("t6_full", iss_ready, 0);
    idle(); rst_n = 0; cyc();
    rst_n = 1; q.delete();
    // Randomized traffic with an MC unit that returns results in order and holds until accepted
    for (int i = 0; i < 3000; i++) begin
      if (last_xf) begin
        void'(q.pop_front());
        mc_valid = 0;
      end
      if (last_acc) q.push_back(iss_wa);
      if (i == 1500) begin
        rst_n = 0; q.delete(); mc_valid = 0;
      end else rst_n = 1;
      if (!mc_valid && q.size() > 0 && $urandom_range(0, 2) == 0) begin
        mc_valid = 1; mc_wa = q[0]; mc_wd = $urandom;
      end
      wb_we  = (m_wait >= LIM) ? 1'b0 : ($urandom_range(0, 3) != 0);
      wb_wa  = 5'($urandom_range(0, 31));
      wb_wd  = $urandom;
      iss_en = $urandom_range(0, 2) == 0;
      iss_wa = 5'($urandom_range(0, 31));
      ra1    = (q.size() > 0 && $urandom_range(0, 1) == 1) ? q[$] : 5'($urandom_range(0, 31));
      ra2    = 5'($urandom_range(0, 31));
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
